// File: rtl/line_data_memory.sv
// Fixed-latency 256-bit line memory behind the data cache's memory-side port.
// Optional sticky protocol checker: define LINE_DATA_MEMORY_PROTOCOL_CHK_EN.
module line_data_memory #(
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o,
  output logic              protocol_err_o
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t            state;
  logic [7:0]        cnt;
  logic              wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] mem [DEPTH];
  logic              unused_addr;

  assign unused_addr = ^{addr_i[4:0], addr_i[31:5]};
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ack_o   <= 1'b0;
      data_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_o  <= 1'b0;
          data_o <= '0;
          if (enable_i) begin
            wr_q    <= write_i;
            idx_q   <= addr_i[5 +: IDX_W];
            wdata_q <= data_i;
            cnt     <= 8'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          // ack/data are registered on entry so they are valid throughout the ACK cycle
          if (cnt == '0) begin
            state  <= ACK;
            ack_o  <= 1'b1;
            data_o <= wr_q ? '0 : mem[idx_q];
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACK: begin
          ack_o  <= 1'b0;
          data_o <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is deliberately not reset; a reset during ACK forces IDLE so nothing commits.
  always_ff @(posedge clk_i) begin
    if (state == ACK && wr_q)
      mem[idx_q] <= wdata_q;
  end

`ifdef LINE_DATA_MEMORY_PROTOCOL_CHK_EN
  logic [26:0] tag_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tag_q          <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      if (state == IDLE && enable_i)
        tag_q <= addr_i[31:5];
      if (state == WAIT &&
          (!enable_i || addr_i[31:5] != tag_q || write_i != wr_q || data_i != wdata_q))
        protocol_err_o <= 1'b1;
    end
  end
`else
  assign protocol_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_line_data_memory.sv
// Scoreboard bench for line_data_memory: LATENCY=10 instance for function, LATENCY=1 for throughput.
module tb_line_data_memory;
  localparam int LAT = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0, wr = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] din = '0;
  logic         ack, busy, perr;
  logic [255:0] dout;

  logic         en1 = 1'b0, wr1 = 1'b0;
  logic [31:0]  addr1 = '0;
  logic [255:0] din1 = '0;
  logic         ack1, busy1, perr1;
  logic [255:0] dout1;

  logic [255:0] model [512];
  logic [255:0] exp_q [$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  line_data_memory #(.LINE_W(256), .DEPTH(512), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .write_i(wr), .addr_i(addr),
    .data_i(din), .ack_o(ack), .data_o(dout), .busy_o(busy), .protocol_err_o(perr)
  );

  line_data_memory #(.LINE_W(256), .DEPTH(512), .LATENCY(1)) dut_fast (
    .clk_i(clk), .rst_i(rst), .enable_i(en1), .write_i(wr1), .addr_i(addr1),
    .data_i(din1), .ack_o(ack1), .data_o(dout1), .busy_o(busy1), .protocol_err_o(perr1)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // One request on the LATENCY=10 instance; perturb moves addr_i mid-WAIT.
  task automatic req(input logic w, input logic [31:0] a, input logic [255:0] d, input bit perturb);
    int n;
    bit seen;
    logic [255:0] e;
    logic [8:0] idx;
    idx = a[13:5];
    if (w) begin
      exp_q.push_back('0);
      model[idx] = d;
    end else begin
      exp_q.push_back(model[idx]);
    end
    @(posedge clk); #1;
    en = 1'b1; wr = w; addr = a; din = d;
    n = 0; seen = 1'b0;
    while (n < 300 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        check("busy_wait", 256'(busy), 256'(1));
        if (perturb) addr = 32'h0000_0080;
      end
      if (perturb && n == 4) check("perr_set", 256'(perr), 256'(1));
      if (ack) seen = 1'b1;
    end
    check("ack_seen", 256'(seen), 256'(1));
    check("ack_latency", 256'(n), 256'(LAT + 2));
    if (seen && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ack_data", dout, e);
    end
    if (perturb) check("perr_sticky", 256'(perr), 256'(1));
    en = 1'b0;
    @(negedge clk);
    check("ack_pulse", 256'(ack), 256'(0));
    check("busy_after", 256'(busy), 256'(0));
    check("data_after", dout, '0);
  endtask

  initial begin
    int acks;
    logic [255:0] a_dat, b_dat, rd;

    repeat (3) @(negedge clk);
    check("rst_ack", 256'(ack), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_data", dout, '0);
    check("rst_perr", 256'(perr), 256'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    req(1'b1, 32'h0000_0040, {8{32'hDEADBEEF}}, 1'b0);
    req(1'b0, 32'h0000_0040, '0, 1'b0);
    check("model_deadbeef", model[2], {8{32'hDEADBEEF}});
    req(1'b0, 32'h0000_005C, '0, 1'b0);
    req(1'b1, 32'h0000_4040, {8{32'h1234_5678}}, 1'b0);
    req(1'b0, 32'h0000_0040, '0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      req(1'b1, 32'((10 + i * 37) << 5) | 32'($urandom_range(0, 31)), rd, 1'b0);
      req(1'b0, 32'((10 + i * 37) << 5), '0, 1'b0);
    end

    // Reset in the middle of a write must drop it: line 7 keeps a_dat.
    a_dat = {8{32'hA5A5_0007}};
    b_dat = {8{32'h5A5A_7000}};
    req(1'b1, 32'h0000_00E0, a_dat, 1'b0);
    @(posedge clk); #1;
    en = 1'b1; wr = 1'b1; addr = 32'h0000_00E0; din = b_dat;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ack", 256'(ack), 256'(0));
    check("midrst_busy", 256'(busy), 256'(0));
    check("midrst_data", dout, '0);
    en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("midrst_no_ack", 256'(acks), 256'(0));
    check("midrst_idle", 256'(busy), 256'(0));
    req(1'b0, 32'h0000_00E0, '0, 1'b0);

    // Back-to-back with enable held high on the LATENCY=1 instance.
    @(posedge clk); #1;
    en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h0000_0020; din1 = {8{32'hCAFE_F00D}};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check($sformatf("b2b_ack_%0d", c), 256'(ack1), 256'((c == 2 || c == 5) ? 1 : 0));
      check($sformatf("b2b_busy_%0d", c), 256'(busy1), 256'((c == 0 || c == 3 || c == 6) ? 0 : 1));
    end
    en1 = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b_idle", 256'(busy1), 256'(0));
    check("b2b_perr", 256'(perr1), 256'(0));

`ifdef LINE_DATA_MEMORY_PROTOCOL_CHK_EN
    check("perr_clear", 256'(perr), 256'(0));
    req(1'b0, 32'h0000_0040, '0, 1'b1);
    repeat (3) @(negedge clk);
    check("perr_hold", 256'(perr), 256'(1));
`else
    check("perr_tied", 256'(perr), 256'(0));
`endif

    check("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/line_data_memory.md
Name: line_data_memory

Overview:
Off-chip data memory model that sits directly downstream of the data cache's memory-side interface. It services one 256-bit cache-line read or write at a time. Each request completes after a fixed, parameterised latency and is acknowledged with a single-cycle pulse. It is the consumer of mem_addr_o, mem_data_o, mem_enable_o and mem_write_o, and the producer of mem_data_i and mem_ack_i.

Parameters:
LINE_W, 256, line width in bits; fixed at 256 by the cache interface.
DEPTH, 512, number of lines stored; must be a power of two.
LATENCY, 10, cycles from request acceptance to ack; legal range 1..255.

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
rst_i  input  1  asynchronous, active-low reset.
enable_i  input  1  request valid (from cache mem_enable_o).
write_i  input  1  1 = line write, 0 = line read.
addr_i  input  32  byte address; bits [4:0] are ignored; line index = addr_i[5 +: log2(DEPTH)].
data_i  input  256  write line data.
ack_o  output  1  one-cycle completion pulse.
data_o  output  256  read line data; valid only while ack_o = 1.
busy_o  output  1  high while a request is outstanding.
protocol_err_o  output  1  sticky protocol error flag (see Optional Feature).

Behaviour:
- Reset (rst_i = 0, asynchronous):
  - State returns to IDLE; cycle counter is cleared.
  - ack_o, busy_o, data_o and protocol_err_o all go to 0.
  - Memory array is not cleared.
  - A request pending at reset is dropped; an in-flight write is not committed.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If enable_i = 1, accept the request: latch write_i, the line index and data_i; load counter = LATENCY-1; go to WAIT. busy_o goes to 1 on the next cycle.
  - Otherwise remain in IDLE.
- WAIT:
  - If counter = 0, go to ACK; otherwise decrement the counter.
  - Inputs are ignored; only the latched request is used.
- ACK:
  - ack_o = 1 for exactly this one cycle.
  - Read: data_o = mem[latched index].
  - Write: mem[latched index] <= latched data at the end of this cycle; data_o = 0.
  - Next state is always IDLE; enable_i is not sampled in the ACK cycle.
- Latency and throughput:
  - Request sampled in cycle T gives ack_o in cycle T+LATENCY+1. Example: LATENCY = 1 means ack at T+2.
  - Minimum spacing between accepts is LATENCY+2 cycles.
- Master contract:
  - The master holds enable_i, write_i, addr_i and data_i stable until it sees ack_o.
  - It may deassert enable_i in the ack cycle or the cycle after.
  - If enable_i is still high in the cycle after ack, that cycle is treated as a new request.
- Read-after-write to the same line: the read returns the newly written data, because the write commits in its ACK cycle, before any later accept.
- Address handling: index bits above log2(DEPTH)+5 are discarded, so the address wraps modulo DEPTH lines.
- Outputs: data_o and ack_o are registered outputs. busy_o = (state != IDLE).

Optional Feature:
- Macro: LINE_DATA_MEMORY_PROTOCOL_CHK_EN.
- Defined:
  - In WAIT, if enable_i = 0, or addr_i[31:5] / write_i / data_i differ from the latched values, set protocol_err_o = 1.
  - protocol_err_o stays set until reset.
  - The request still completes using the latched values.
- Undefined: protocol_err_o is tied to 0 and the comparison logic is not built.

Test Plan:
- Reset: hold rst_i = 0 mid-WAIT, then release -> ack_o, busy_o and data_o are 0, the FSM is in IDLE, and no ack follows.
- Write then read, LATENCY = 10:
  - Write addr 0x0000_0040, data {8{32'hDEADBEEF}} at cycle T -> ack_o pulses at T+11 for exactly 1 cycle.
  - Read of 0x0000_0040 -> data_o = {8{32'hDEADBEEF}} in its ack cycle.
- Offset ignored: read addr 0x0000_005C -> same line as 0x40, same data returned.
- Wrap-around with DEPTH = 512: write 0x0000_4040 (index 2 modulo 512) -> a later read of 0x0000_0040 returns that data.
- Back-to-back with LATENCY = 1: enable_i held high continuously -> accepts at T and T+3, acks at T+2 and T+5, busy_o low only in cycles T and T+3.
- With LINE_DATA_MEMORY_PROTOCOL_CHK_EN, LATENCY = 10: change addr_i to 0x80 in WAIT -> protocol_err_o = 1 next cycle and stays set; the ack still returns data from the original address 0x40.
